// File: rtl/datapath.sv
// datapath: three general registers R0..R2, an accumulator A, and carry/zero
// flags around a small 8-function ALU.
//
// Ports:
//   clk            clock; all state changes on the rising edge
//   reset          asynchronous, active-high; R*/A/C cleared, Z set
//   clr_i          synchronous clear; wins over every clock enable
//   ce_i[3:0]      enables: bits 0..2 enable R0..R2, bit 3 enables A, C and Z together
//   w_i[2:0]       Rk source select: 0 = external Mk, 1 = accumulator A
//   sel_i[1:0]     ALU B operand: 00 R0, 01 R1, 10 R2, 11 A
//   s_i[2:0]       ALU opcode (ADC, SBC, PASS B, PASS A, AND, OR, XOR, NOT A)
//   cin_i          ALU carry-in, used by ADC/SBC only
//   m0_i..m2_i     external operands
//   r0_o..r2_o     register contents
//   a_o            accumulator contents
//   c_o, z_o       registered carry and zero flags
//   alu_o          combinational ALU result, for observation
module datapath #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic [3:0]       ce_i,
  input  logic [2:0]       w_i,
  input  logic [1:0]       sel_i,
  input  logic [2:0]       s_i,
  input  logic             cin_i,
  input  logic [WIDTH-1:0] m0_i,
  input  logic [WIDTH-1:0] m1_i,
  input  logic [WIDTH-1:0] m2_i,
  output logic [WIDTH-1:0] r0_o,
  output logic [WIDTH-1:0] r1_o,
  output logic [WIDTH-1:0] r2_o,
  output logic [WIDTH-1:0] a_o,
  output logic             c_o,
  output logic             z_o,
  output logic [WIDTH-1:0] alu_o
);

  logic [WIDTH-1:0] r0_q, r1_q, r2_q, a_q;
  logic [WIDTH-1:0] r0_d, r1_d, r2_d, a_d;
  logic             c_q, z_q, c_d, z_d;

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   res;

  // B operand select
  always_comb begin
    b_op = r0_q;
    case (sel_i)
      2'b00:   b_op = r0_q;
      2'b01:   b_op = r1_q;
      2'b10:   b_op = r2_q;
      default: b_op = a_q;
    endcase
  end

  // ALU at WIDTH+1 bits; the top bit is the carry-out and is only ever set
  // by the two arithmetic opcodes.
  always_comb begin
    res = '0;
    case (s_i)
      3'b000:  res = {1'b0, a_q} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin_i};
      3'b001:  res = {1'b0, a_q} + {1'b0, ~b_op} + {{WIDTH{1'b0}}, cin_i};
      3'b010:  res = {1'b0, b_op};
      3'b011:  res = {1'b0, a_q};
      3'b100:  res = {1'b0, a_q & b_op};
      3'b101:  res = {1'b0, a_q | b_op};
      3'b110:  res = {1'b0, a_q ^ b_op};
      default: res = {1'b0, ~a_q};
    endcase
  end

  assign alu_o = res[WIDTH-1:0];

  // Next state. Every path reads the current (pre-edge) register values, so
  // an Rk loaded from A on the same edge that A updates receives the old A.
  always_comb begin
    r0_d = r0_q;
    r1_d = r1_q;
    r2_d = r2_q;
    a_d  = a_q;
    c_d  = c_q;
    z_d  = z_q;
    if (clr_i) begin
      r0_d = '0;
      r1_d = '0;
      r2_d = '0;
      a_d  = '0;
      c_d  = 1'b0;
      z_d  = 1'b1;
    end else begin
      if (ce_i[0]) r0_d = w_i[0] ? a_q : m0_i;
      if (ce_i[1]) r1_d = w_i[1] ? a_q : m1_i;
      if (ce_i[2]) r2_d = w_i[2] ? a_q : m2_i;
      if (ce_i[3]) begin
        a_d = res[WIDTH-1:0];
        c_d = res[WIDTH];
        z_d = (res[WIDTH-1:0] == '0);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
      a_q  <= '0;
      c_q  <= 1'b0;
      z_q  <= 1'b1;
    end else begin
      r0_q <= r0_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      a_q  <= a_d;
      c_q  <= c_d;
      z_q  <= z_d;
    end
  end

  assign r0_o = r0_q;
  assign r1_o = r1_q;
  assign r2_o = r2_q;
  assign a_o  = a_q;
  assign c_o  = c_q;
  assign z_o  = z_q;

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

  logic       clk;
  logic       reset;
  logic       clr_i;
  logic [3:0] ce_i;
  logic [2:0] w_i;
  logic [1:0] sel_i;
  logic [2:0] s_i;
  logic       cin_i;
  logic [3:0] m0_i, m1_i, m2_i;
  logic [3:0] r0_o, r1_o, r2_o, a_o, alu_o;
  logic       c_o, z_o;

  int checks = 0;
  int errors = 0;

  datapath #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr_i),
    .ce_i  (ce_i),
    .w_i   (w_i),
    .sel_i (sel_i),
    .s_i   (s_i),
    .cin_i (cin_i),
    .m0_i  (m0_i),
    .m1_i  (m1_i),
    .m2_i  (m2_i),
    .r0_o  (r0_o),
    .r1_o  (r1_o),
    .r2_o  (r2_o),
    .a_o   (a_o),
    .c_o   (c_o),
    .z_o   (z_o),
    .alu_o (alu_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       clr;
    logic [3:0] ce;
    logic [2:0] w;
    logic [1:0] sel;
    logic [2:0] s;
    logic       cin;
    logic [3:0] m0, m1, m2;
    logic [3:0] alu;  // expected pre-edge ALU output
    logic [3:0] r0, r1, r2, a;  // expected state after the edge
    logic       c, z;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] r0, input logic [3:0] r1,
                             input logic [3:0] r2, input logic [3:0] a, input logic c,
                             input logic z);
    check({tag, " r0"}, int'(r0_o), int'(r0));
    check({tag, " r1"}, int'(r1_o), int'(r1));
    check({tag, " r2"}, int'(r2_o), int'(r2));
    check({tag, " a"},  int'(a_o),  int'(a));
    check({tag, " c"},  int'(c_o),  int'(c));
    check({tag, " z"},  int'(z_o),  int'(z));
  endtask

  task automatic drive(input logic clr, input logic [3:0] ce, input logic [2:0] w,
                       input logic [1:0] sel, input logic [2:0] s, input logic cin,
                       input logic [3:0] m0, input logic [3:0] m1, input logic [3:0] m2);
    clr_i = clr; ce_i = ce; w_i = w; sel_i = sel; s_i = s; cin_i = cin;
    m0_i = m0; m1_i = m1; m2_i = m2;
  endtask

  initial begin
    // clr  ce       w       sel    s       cin   m0     m1     m2     alu     r0     r1     r2     a      c     z
    vecs[0]  = '{1'b0, 4'b0111, 3'b000, 2'b00, 3'b010, 1'b0, 4'd5,  4'd3,  4'd9,  4'd0,  4'd5, 4'd3, 4'd9, 4'd0,  1'b0, 1'b1};
    vecs[1]  = '{1'b0, 4'b1000, 3'b000, 2'b00, 3'b010, 1'b0, 4'd0,  4'd0,  4'd0,  4'd5,  4'd5, 4'd3, 4'd9, 4'd5,  1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1000, 3'b000, 2'b01, 3'b001, 1'b1, 4'd0,  4'd0,  4'd0,  4'd2,  4'd5, 4'd3, 4'd9, 4'd2,  1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'b0100, 3'b100, 2'b11, 3'b011, 1'b0, 4'd0,  4'd0,  4'd0,  4'd2,  4'd5, 4'd3, 4'd2, 4'd2,  1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'b0011, 3'b000, 2'b00, 3'b111, 1'b0, 4'd3,  4'd5,  4'd0,  4'd13, 4'd3, 4'd5, 4'd2, 4'd2,  1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'b1000, 3'b000, 2'b00, 3'b010, 1'b0, 4'd0,  4'd0,  4'd0,  4'd3,  4'd3, 4'd5, 4'd2, 4'd3,  1'b0, 1'b0};
    vecs[6]  = '{1'b0, 4'b1000, 3'b000, 2'b01, 3'b001, 1'b1, 4'd0,  4'd0,  4'd0,  4'd14, 4'd3, 4'd5, 4'd2, 4'd14, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'b0001, 3'b000, 2'b01, 3'b100, 1'b0, 4'd1,  4'd0,  4'd0,  4'd4,  4'd1, 4'd5, 4'd2, 4'd14, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 4'b1000, 3'b000, 2'b00, 3'b101, 1'b0, 4'd0,  4'd0,  4'd0,  4'd15, 4'd1, 4'd5, 4'd2, 4'd15, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'b1000, 3'b000, 2'b00, 3'b000, 1'b0, 4'd0,  4'd0,  4'd0,  4'd0,  4'd1, 4'd5, 4'd2, 4'd0,  1'b1, 1'b1};
    vecs[10] = '{1'b0, 4'b1000, 3'b000, 2'b01, 3'b110, 1'b0, 4'd0,  4'd0,  4'd0,  4'd5,  4'd1, 4'd5, 4'd2, 4'd5,  1'b0, 1'b0};
    // A and R0<-A on the same edge: R0 gets the old A
    vecs[11] = '{1'b0, 4'b1001, 3'b001, 2'b11, 3'b111, 1'b0, 4'd0,  4'd0,  4'd0,  4'd10, 4'd5, 4'd5, 4'd2, 4'd10, 1'b0, 1'b0};
    // ce=0000 for three edges with busy inputs: nothing moves
    vecs[12] = '{1'b0, 4'b0000, 3'b111, 2'b00, 3'b000, 1'b1, 4'd15, 4'd15, 4'd15, 4'd0,  4'd5, 4'd5, 4'd2, 4'd10, 1'b0, 1'b0};
    vecs[13] = vecs[12];
    vecs[14] = vecs[12];
    // clear beats every enable
    vecs[15] = '{1'b1, 4'b1111, 3'b000, 2'b10, 3'b010, 1'b0, 4'd7,  4'd7,  4'd7,  4'd2,  4'd0, 4'd0, 4'd0, 4'd0,  1'b0, 1'b1};
    vecs[16] = '{1'b0, 4'b1000, 3'b000, 2'b00, 3'b001, 1'b0, 4'd0,  4'd0,  4'd0,  4'd15, 4'd0, 4'd0, 4'd0, 4'd15, 1'b0, 1'b0};

    reset = 1'b0;
    drive(1'b0, 4'b0000, 3'b000, 2'b00, 3'b000, 1'b0, 4'd0, 4'd0, 4'd0);
    #1 reset = 1'b1;
    #1 check_state("reset", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    check("reset alu", int'(alu_o), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].clr, vecs[i].ce, vecs[i].w, vecs[i].sel, vecs[i].s, vecs[i].cin,
            vecs[i].m0, vecs[i].m1, vecs[i].m2);
      #1 check($sformatf("v%0d alu", i), int'(alu_o), int'(vecs[i].alu));
      @(posedge clk);
      #1 check_state($sformatf("v%0d", i), vecs[i].r0, vecs[i].r1, vecs[i].r2, vecs[i].a,
                     vecs[i].c, vecs[i].z);
      @(negedge clk);
    end

    // Async reset in the middle of an SBC cycle. State: R0=6 R1=2 R2=1 A=15.
    drive(1'b0, 4'b0111, 3'b000, 2'b00, 3'b010, 1'b0, 4'd6, 4'd2, 4'd1);
    @(posedge clk);
    #1 check_state("preload", 4'd6, 4'd2, 4'd1, 4'd15, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 4'b1000, 3'b000, 2'b01, 3'b001, 1'b1, 4'd0, 4'd0, 4'd0);
    #1 check("sbc alu", int'(alu_o), 13);  // 15 + ~2 + 1 = 13, carry out
    #1 reset = 1'b1;
    #1 check_state("async", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    @(posedge clk);
    #1 check_state("held", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    // First edge after release loads: 0 + ~0 + 1 = 16 -> A=0, C=1, Z=1, and R0 from M0
    drive(1'b0, 4'b1001, 3'b000, 2'b01, 3'b001, 1'b1, 4'd7, 4'd0, 4'd0);
    @(posedge clk);
    #1 check_state("release", 4'd7, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 Parameter WIDTH, default 4, data width of registers, M inputs and ALU.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 clr_i  input  1  synchronous clear of all state registers.
REQ-005 ce_i  input  4  clock enables; bit k enables Rk (k=0..2), bit 3 enables A, C and Z.
REQ-006 w_i  input  3  2:1 mux selects; bit k: 0 loads Rk from Mk, 1 loads Rk from A.
REQ-007 sel_i  input  2  B-operand select: 00 R0, 01 R1, 10 R2, 11 A.
REQ-008 s_i  input  3  ALU opcode.
REQ-009 cin_i  input  1  ALU carry-in.
REQ-010 m0_i, m1_i, m2_i  input  WIDTH each  external operands M0..M2.
REQ-011 r0_o, r1_o, r2_o, a_o  output  WIDTH each  register contents.
REQ-012 c_o  output  1  registered carry flag.
REQ-013 z_o  output  1  registered zero flag.
REQ-014 alu_o  output  WIDTH  combinational ALU result, for observation.

Function
REQ-015 ALU operand A SHALL be register A; operand B SHALL be the sel_i-selected value.
REQ-016 The ALU SHALL implement, at WIDTH+1 bits internally:
- 000 ADC: A+B+cin_i
- 001 SBC: A+~B+cin_i
- 010 PASS B
- 011 PASS A
- 100 A&B
- 101 A|B
- 110 A^B
- 111 ~A
REQ-017 alu_o SHALL be the low WIDTH bits of the result; bit WIDTH is the carry-out.
REQ-018 Carry-out SHALL be 0 for opcodes 010-111.
REQ-019 With clr_i=0 and ce_i[k]=1 (k=0..2), Rk SHALL load (w_i[k] ? A : Mk) on the next edge; otherwise Rk holds.
REQ-020 With clr_i=0 and ce_i[3]=1, A SHALL load alu_o, C SHALL load the carry-out, and Z SHALL load (alu_o==0), all on the same edge.
REQ-021 With ce_i[3]=0, A, C and Z SHALL hold.
REQ-022 Mux and ALU paths SHALL use pre-edge register values; when A is loaded and also selected as an Rk source on the same edge, Rk SHALL receive the old A.
REQ-023 clr_i=1 SHALL zero R0, R1, R2, A and C, and set Z=1, on the next edge, regardless of ce_i.
REQ-024 ce_i=0000 with clr_i=0 SHALL leave all state unchanged indefinitely.
REQ-025 ALU arithmetic SHALL wrap modulo 2^WIDTH, with overflow reported only through C.
REQ-026 All register outputs SHALL be driven directly from flops, with no combinational path from inputs.
REQ-027 alu_o SHALL be the only combinational output.

Reset
REQ-028 reset=1 SHALL immediately force R0=R1=R2=A=0, C=0 and Z=1, independent of clk.
REQ-029 While reset=1, all other inputs SHALL be ignored.
REQ-030 Reset asserted mid-sequence SHALL discard the in-flight load.
REQ-031 After reset deassertion, the first state update SHALL occur on the first rising edge with reset low.

Verification
REQ-032 Reset, then clr_i=0, ce=0111, w=000, M0=5, M1=3, M2=9 -> after one edge R0=5, R1=3, R2=9, A=0, Z=1.
REQ-033 Full sequence from REQ-032 state:
- ce=1000, sel=00, s=010 -> A=5, C=0, Z=0
- ce=1000, sel=01, s=001, cin=1 -> A=2, C=1
- ce=0100, w=100 -> R2=2, A=2
REQ-034 Borrow case: A=3, R1=5, sel=01, s=001, cin=1, ce=1000 -> A=14, C=0, Z=0.
REQ-035 ADC overflow case: A=15, R0=1, sel=00, s=000, cin=0 -> A=0, C=1, Z=1.
REQ-036 Priority and hold:
- clr_i=1 with ce=1111 -> all registers 0, C=0, Z=1
- ce=0000 for 3 edges -> no state change
REQ-037 Asynchronous reset pulse between edges during an SBC cycle -> outputs zero immediately, no load at the next edge.
